// File: rtl/packet_steer_pkg.sv
// packet_steer_pkg
// Shared definitions for the packet_steer block: FSM / routing-target
// encoding, the location of the destination-port field inside tuser, the
// default capture-port mask, and the first-beat routing decision.
package packet_steer_pkg;

    // FSM state encoding; FWD/CAP/DROP double as the routing target code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_CAP  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    // Destination-port field inside tuser.
    localparam int DST_PORT_LSB = 24;
    localparam int DST_PORT_MSB = 31;

    // dst_port bits that steer a packet to the capture port by default.
    localparam logic [7:0] CAPTURE_PORT_MASK_DFLT = 8'hAA;

    // First-beat routing decision: any capture bit wins, any other
    // nonzero destination forwards, an empty destination drops.
    function automatic state_e decide_target(input logic [7:0] dst,
                                             input logic [7:0] mask);
        state_e tgt;
        if ((dst & mask) != 8'h00) begin
            tgt = ST_CAP;
        end else if (dst != 8'h00) begin
            tgt = ST_FWD;
        end else begin
            tgt = ST_DROP;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/packet_steer_axis_out_reg.sv
// axis_out_reg
// One-entry AXI4-Stream output register with a valid flag. A load always
// wins over a drain in the same cycle, so a fully-ready consumer sees one
// beat per cycle. While valid is high and the consumer stalls, the held
// beat does not change.
module axis_out_reg #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] strb_i,
    input  logic [USER_W-1:0]   user_i,
    input  logic                last_i,
    input  logic                tready_i,
    output logic                tvalid_o,
    output logic [DATA_W-1:0]   tdata_o,
    output logic [DATA_W/8-1:0] tstrb_o,
    output logic [USER_W-1:0]   tuser_o,
    output logic                tlast_o
);

    logic                tvalid_q, tvalid_d;
    logic [DATA_W-1:0]   tdata_q,  tdata_d;
    logic [DATA_W/8-1:0] tstrb_q,  tstrb_d;
    logic [USER_W-1:0]   tuser_q,  tuser_d;
    logic                tlast_q,  tlast_d;

    // Next-state: load a new beat, otherwise drain on handshake, otherwise hold.
    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        if (load_i) begin
            tvalid_d = 1'b1;
            tdata_d  = data_i;
            tstrb_d  = strb_i;
            tuser_d  = user_i;
            tlast_d  = last_i;
        end else if (tvalid_q && tready_i) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid_o = tvalid_q;
    assign tdata_o  = tdata_q;
    assign tstrb_o  = tstrb_q;
    assign tuser_o  = tuser_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/packet_steer.sv
// packet_steer
// Splits the merged AXI4-Stream back into a forward stream (port 0) and a
// capture stream (port 1), one packet at a time, dropping packets with an
// empty destination. Routing is decided on the first beat from
// tuser[31:24] and held for the rest of the packet.
// Optional feature macro: PACKET_STEER_STATS_EN builds the three packet
// counters; without it the counter outputs are tied to zero.
module packet_steer
    import packet_steer_pkg::*;
#(
    parameter int         C_M_AXIS_DATA_WIDTH  = 256,
    parameter int         C_S_AXIS_DATA_WIDTH  = 256,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter int         C_S_AXIS_TUSER_WIDTH = 128,
    parameter logic [7:0] CAPTURE_PORT_MASK    = CAPTURE_PORT_MASK_DFLT
) (
    input  logic                                axi_aclk,
    input  logic                                axi_aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    input  logic                                s_axis_tlast,
    output logic                                s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_0,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_0,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_0,
    output logic                                m_axis_tvalid_0,
    output logic                                m_axis_tlast_0,
    input  logic                                m_axis_tready_0,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata_1,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb_1,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser_1,
    output logic                                m_axis_tvalid_1,
    output logic                                m_axis_tlast_1,
    input  logic                                m_axis_tready_1,

    output logic [31:0]                         fwd_pkt_count,
    output logic [31:0]                         cap_pkt_count,
    output logic [31:0]                         drop_pkt_count
);

    state_e      state_q, state_d;
    state_e      tgt_s;
    logic [7:0]  dst_s;
    logic        ready_s;
    logic        accept_s;
    logic        load_fwd_s;
    logic        load_cap_s;

    assign dst_s = s_axis_tuser[DST_PORT_MSB:DST_PORT_LSB];

    // Target of the beat on the input: fresh decision in IDLE, sticky otherwise.
    always_comb begin
        tgt_s = ST_DROP;
        case (state_q)
            ST_IDLE: tgt_s = decide_target(dst_s, CAPTURE_PORT_MASK);
            ST_FWD:  tgt_s = ST_FWD;
            ST_CAP:  tgt_s = ST_CAP;
            ST_DROP: tgt_s = ST_DROP;
            default: tgt_s = ST_DROP;
        endcase
    end

    // Input backpressure follows only the targeted port; drops never stall.
    always_comb begin
        ready_s = 1'b1;
        case (tgt_s)
            ST_FWD:  ready_s = !m_axis_tvalid_0 || m_axis_tready_0;
            ST_CAP:  ready_s = !m_axis_tvalid_1 || m_axis_tready_1;
            ST_DROP: ready_s = 1'b1;
            default: ready_s = 1'b1;
        endcase
    end

    assign s_axis_tready = ready_s;
    assign accept_s      = s_axis_tvalid && ready_s;
    assign load_fwd_s    = accept_s && (tgt_s == ST_FWD);
    assign load_cap_s    = accept_s && (tgt_s == ST_CAP);

    // FSM next state: an accepted tlast closes the packet, any other accepted
    // beat keeps (or enters) the target state.
    always_comb begin
        state_d = state_q;
        if (accept_s) begin
            if (s_axis_tlast) begin
                state_d = ST_IDLE;
            end else begin
                state_d = tgt_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    // FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    axis_out_reg #(
        .DATA_W (C_M_AXIS_DATA_WIDTH),
        .USER_W (C_M_AXIS_TUSER_WIDTH)
    ) u_out_fwd (
        .clk_i    (axi_aclk),
        .rst_n_i  (axi_aresetn),
        .load_i   (load_fwd_s),
        .data_i   (s_axis_tdata),
        .strb_i   (s_axis_tstrb),
        .user_i   (s_axis_tuser),
        .last_i   (s_axis_tlast),
        .tready_i (m_axis_tready_0),
        .tvalid_o (m_axis_tvalid_0),
        .tdata_o  (m_axis_tdata_0),
        .tstrb_o  (m_axis_tstrb_0),
        .tuser_o  (m_axis_tuser_0),
        .tlast_o  (m_axis_tlast_0)
    );

    axis_out_reg #(
        .DATA_W (C_M_AXIS_DATA_WIDTH),
        .USER_W (C_M_AXIS_TUSER_WIDTH)
    ) u_out_cap (
        .clk_i    (axi_aclk),
        .rst_n_i  (axi_aresetn),
        .load_i   (load_cap_s),
        .data_i   (s_axis_tdata),
        .strb_i   (s_axis_tstrb),
        .user_i   (s_axis_tuser),
        .last_i   (s_axis_tlast),
        .tready_i (m_axis_tready_1),
        .tvalid_o (m_axis_tvalid_1),
        .tdata_o  (m_axis_tdata_1),
        .tstrb_o  (m_axis_tstrb_1),
        .tuser_o  (m_axis_tuser_1),
        .tlast_o  (m_axis_tlast_1)
    );

`ifdef PACKET_STEER_STATS_EN
    logic [31:0] fwd_cnt_q,  fwd_cnt_d;
    logic [31:0] cap_cnt_q,  cap_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Count a packet when its tlast beat is accepted; counters wrap naturally.
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (accept_s && s_axis_tlast) begin
            case (tgt_s)
                ST_FWD:  fwd_cnt_d  = fwd_cnt_q  + 32'd1;
                ST_CAP:  cap_cnt_d  = cap_cnt_q  + 32'd1;
                ST_DROP: drop_cnt_d = drop_cnt_q + 32'd1;
                default: drop_cnt_d = drop_cnt_q;
            endcase
        end else begin
            fwd_cnt_d  = fwd_cnt_q;
        end
    end

    // Packet statistics registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            fwd_cnt_q  <= 32'h0;
            cap_cnt_q  <= 32'h0;
            drop_cnt_q <= 32'h0;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            cap_cnt_q  <= cap_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fwd_pkt_count  = fwd_cnt_q;
    assign cap_pkt_count  = cap_cnt_q;
    assign drop_pkt_count = drop_cnt_q;
`else
    assign fwd_pkt_count  = 32'h0;
    assign cap_pkt_count  = 32'h0;
    assign drop_pkt_count = 32'h0;
`endif

endmodule

// File: doc/packet_steer.md
# packet_steer

Receive-side counterpart of the capture path's duplicate-and-merge stage. It takes the single merged AXI4-Stream (NetFPGA-10G 256-bit data, 128-bit tuser) and splits it back into two streams, one packet at a time. The split uses the destination-port field in tuser: packets go to the forwarding port (0), the capture port (1), or are dropped. It sits downstream of the output-port lookup and upstream of the output queues.

## Interface
Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master data width (both master ports)
- C_S_AXIS_DATA_WIDTH, 256, slave data width; must equal master width
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal master width
- CAPTURE_PORT_MASK, 8'hAA, dst_port bits (tuser[31:24]) that select the capture port

Ports:
- axi_aclk  in  1  single clock for the whole block
- axi_aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  merged input stream
- s_axis_tready  out  1  input backpressure
- m_axis_tdata_0/tstrb_0/tuser_0/tvalid_0/tlast_0  out  256/32/128/1/1  forward stream
- m_axis_tready_0  in  1  forward backpressure
- m_axis_tdata_1/tstrb_1/tuser_1/tvalid_1/tlast_1  out  256/32/128/1/1  capture stream
- m_axis_tready_1  in  1  capture backpressure
- fwd_pkt_count, cap_pkt_count, drop_pkt_count  out  32 each  packet statistics (ro_regs)

## Operation
- Decision, made on the first beat only, from d = s_axis_tuser[31:24]:
  - if d & CAPTURE_PORT_MASK is nonzero: target CAP
  - else if d is nonzero: target FWD
  - else (d == 0): target DROP
- FSM states: IDLE, FWD, CAP, DROP. Reset state is IDLE.
- IDLE: a beat is accepted when s_axis_tvalid & s_axis_tready.
  - The accepted beat goes to the decided target.
  - Next state: the target if tlast=0, otherwise IDLE (single-beat packet).
- FWD / CAP / DROP: every accepted beat follows the current state. An accepted beat with tlast=1 returns to IDLE.
- The decision is sticky for the whole packet. tuser on later beats is ignored for routing, but passed through unchanged.
- Each master port has a one-entry output register holding data/strb/user/last, plus a valid flag.
  - The register loads when a beat is accepted for that port.
  - valid clears on tready & valid when no new beat loads in the same cycle.
- s_axis_tready = (state target is DROP) | !valid_x | m_axis_tready_x, where x is the current or decided target port. The other port's tready has no effect.
- DROP consumes beats at one per cycle and drives nothing out.
- Counters increment on acceptance of a tlast beat for their target, and wrap from 2^32-1 to 0.
- Reset mid-packet: the FSM returns to IDLE, all tvalid outputs drop, registers clear. The next beat is treated as a first beat.

## Timing
- Latency: input beat to m_axis_tvalid_x is 1 cycle. Full throughput of one beat per cycle while the target port is ready.
- Reset values: m_axis_tvalid_0/1 = 0; tdata/tstrb/tuser/tlast = 0; counters = 0.
- s_axis_tready is combinational from the FSM, the output valid flags and m_axis_tready_x. It does not depend on s_axis_tvalid.
- Master outputs hold stable while tvalid=1 & tready=0 (AXI4-Stream rule).
- Simultaneous load and drain on one port in the same cycle: the new beat wins and valid stays 1.
- Back-to-back packets to different ports: the first beat of the new packet is accepted in the cycle after the previous tlast. No bubble is required.

## Configuration
- PACKET_STEER_STATS_EN defined: the three counters are implemented as specified.
- Not defined: the counters are not built, and all three count outputs are tied to 32'h0.

## Structure
- Shared package packet_steer_pkg contains:
  - FSM state encoding (IDLE=0, FWD=1, CAP=2, DROP=3)
  - DST_PORT_LSB=24, DST_PORT_MSB=31
  - the default CAPTURE_PORT_MASK
- Sub-module axis_out_reg: the one-entry output register with valid flag, instantiated twice (port 0 and port 1).

## Test plan
- Single 1-beat packet, dst=8'h01, both readies=1 -> m_axis_tvalid_0 high 1 cycle later with identical data/tuser; fwd_pkt_count=1.
- 4-beat packet, dst=8'h02, tuser changed to 8'h01 on beat 2 -> all 4 beats appear on port 1 only, tlast on beat 4; cap_pkt_count=1.
- Packet with dst=8'h00, 3 beats -> s_axis_tready=1 for all 3 cycles, no master tvalid; drop_pkt_count=1.
- Capture packet with m_axis_tready_1=0 for 5 cycles, m_axis_tready_0=1 -> s_axis_tready=0 after the first beat loads; port-1 output held stable; resumes with no beats lost or duplicated.
- Back-to-back FWD then CAP 2-beat packets, both readies=1 -> 4 consecutive input accepts with no bubble, 2 beats on each port.
- axi_aresetn asserted mid-way through a 4-beat packet (beat 2) -> all tvalid=0 and counters=0. The next first beat with dst=8'h01 is routed to port 0.
